// File: rtl/hp_rd_req_sched.sv
// Read-request scheduler for ping-pong host huge pages: splits the ready page into chunk reads
// bounded by length, max read size, 4KB boundary, RX buffer space and outstanding tags.
module hp_rd_req_sched #(
  parameter int unsigned MAX_RD_QW       = 64,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic [63:0] hp_addr_0,
  input  logic [63:0] hp_addr_1,
  input  logic [18:0] hp_len_qw_0,
  input  logic [18:0] hp_len_qw_1,
  input  logic        hp_ready_0,
  input  logic        hp_ready_1,
  output logic        hp_release_0,
  output logic        hp_release_1,
  input  logic [9:0]  rx_free_qw,
  input  logic        chunk_cpl,
  input  logic [8:0]  cpl_qw,
  output logic [63:0] huge_page_addr,
  output logic [8:0]  qwords_to_rd,
  output logic        read_chunk,
  input  logic        read_chunk_ack,
  output logic        send_huge_page_rd_completed,
  input  logic        send_huge_page_rd_completed_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StReq,
    StWaitCpl,
    StDone,
    StRelease
  } state_e;

  localparam logic [18:0] MaxRdQw = 19'(MAX_RD_QW);
  localparam logic [4:0]  MaxOut  = 5'(MAX_OUTSTANDING);

  state_e      state_q, state_d;
  logic        idx_q, idx_d;
  logic [63:0] addr_q, addr_d;
  logic [18:0] remaining_q, remaining_d;
  logic [8:0]  chunk_q, chunk_d;
  logic [4:0]  outstanding_q, outstanding_d;
  logic [13:0] reserved_q, reserved_d;
  logic        read_chunk_q, read_chunk_d;

  logic [18:0] boundary_qw;
  logic [18:0] len_capped;
  logic [18:0] chunk_calc;
  logic [8:0]  chunk_eval;
  logic [14:0] need_qw;
  logic        space_ok;
  logic        tag_ok;
  logic        can_issue;
  logic        issue;
  logic        page_ready;
  logic [63:0] page_addr;
  logic [18:0] page_len;
  logic [4:0]  out_inc;
  logic [13:0] res_inc;

  // Qwords left before the next 4KB boundary (1..512).
  assign boundary_qw = 19'd512 - {10'd0, addr_q[11:3]};
  assign len_capped  = (remaining_q < MaxRdQw) ? remaining_q : MaxRdQw;
  assign chunk_calc  = (len_capped < boundary_qw) ? len_capped : boundary_qw;

  // In CALC the chunk is not registered yet, so evaluate issue against the freshly computed size.
  assign chunk_eval = (state_q == StCalc) ? chunk_calc[8:0] : chunk_q;
  assign need_qw    = {6'd0, chunk_eval} + {1'b0, reserved_q};
  assign space_ok   = need_qw <= {5'd0, rx_free_qw};
  assign tag_ok     = outstanding_q < MaxOut;
  assign can_issue  = space_ok && tag_ok;
  assign issue      = (state_q == StReq) && read_chunk_q && read_chunk_ack;

  assign page_ready = idx_q ? hp_ready_1 : hp_ready_0;
  assign page_addr  = idx_q ? hp_addr_1 : hp_addr_0;
  assign page_len   = idx_q ? hp_len_qw_1 : hp_len_qw_0;

  // Tag and RX-space accounting; an issue and a completion in the same cycle both apply.
  always_comb begin
    out_inc = outstanding_q + {4'd0, issue};
    if (chunk_cpl && (out_inc != 5'd0)) begin
      outstanding_d = out_inc - 5'd1;
    end else begin
      outstanding_d = out_inc;
    end
    res_inc = reserved_q + (issue ? {5'd0, chunk_q} : 14'd0);
    if (chunk_cpl) begin
      reserved_d = (res_inc > {5'd0, cpl_qw}) ? (res_inc - {5'd0, cpl_qw}) : 14'd0;
    end else begin
      reserved_d = res_inc;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    chunk_d      = chunk_q;
    read_chunk_d = read_chunk_q;
    unique case (state_q)
      StIdle: begin
        if (page_ready) begin
          addr_d      = {page_addr[63:3], 3'b000};
          remaining_d = page_len;
          state_d     = StCalc;
        end
      end
      StCalc: begin
        if (remaining_q == 19'd0) begin
          state_d = StWaitCpl;
        end else begin
          chunk_d      = chunk_calc[8:0];
          read_chunk_d = can_issue;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (read_chunk_q) begin
          if (read_chunk_ack) begin
            read_chunk_d = 1'b0;
            addr_d       = addr_q + {52'd0, chunk_q, 3'b000};
            remaining_d  = remaining_q - {10'd0, chunk_q};
            state_d      = StCalc;
          end
        end else if (can_issue) begin
          read_chunk_d = 1'b1;
        end
      end
      StWaitCpl: begin
        if (outstanding_q == 5'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (send_huge_page_rd_completed_ack) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        idx_d   = ~idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= 1'b0;
      addr_q        <= 64'd0;
      remaining_q   <= 19'd0;
      chunk_q       <= 9'd0;
      outstanding_q <= 5'd0;
      reserved_q    <= 14'd0;
      read_chunk_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      chunk_q       <= chunk_d;
      outstanding_q <= outstanding_d;
      reserved_q    <= reserved_d;
      read_chunk_q  <= read_chunk_d;
    end
  end

  assign huge_page_addr              = addr_q;
  assign qwords_to_rd                = chunk_q;
  assign read_chunk                  = read_chunk_q;
  assign send_huge_page_rd_completed = (state_q == StDone);
  assign hp_release_0                = (state_q == StRelease) && !idx_q;
  assign hp_release_1                = (state_q == StRelease) && idx_q;
  assign busy                        = (state_q != StIdle);

  // Byte-offset bits of the page addresses and the upper chunk bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{hp_addr_0[2:0], hp_addr_1[2:0], chunk_calc[18:9]};

endmodule

// File: tb/tb_hp_rd_req_sched.sv
// Directed bench for hp_rd_req_sched: default instance plus a MAX_RD_QW=8 instance for tag limits.
module tb_hp_rd_req_sched;

  logic        trn_clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] hp_addr_0 = '0, hp_addr_1 = '0;
  logic [18:0] hp_len_qw_0 = '0, hp_len_qw_1 = '0;
  logic        hp_ready_0 = 1'b0, hp_ready_1 = 1'b0;
  logic        hp_release_0, hp_release_1;
  logic [9:0]  rx_free_qw = '0;
  logic        chunk_cpl = 1'b0;
  logic [8:0]  cpl_qw = '0;
  logic [63:0] huge_page_addr;
  logic [8:0]  qwords_to_rd;
  logic        read_chunk;
  logic        read_chunk_ack = 1'b0;
  logic        send_cmp;
  logic        send_cmp_ack = 1'b0;
  logic        busy;

  logic        b_ready_0 = 1'b0, b_ready_1 = 1'b0;
  logic        b_release_0, b_release_1;
  logic        b_cpl = 1'b0;
  logic [63:0] b_addr;
  logic [8:0]  b_qw;
  logic        b_read;
  logic        b_ack = 1'b0;
  logic        b_cmp;
  logic        b_busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 trn_clk = ~trn_clk;

  hp_rd_req_sched dut (
    .trn_clk                         (trn_clk),
    .reset                           (reset),
    .hp_addr_0                       (hp_addr_0),
    .hp_addr_1                       (hp_addr_1),
    .hp_len_qw_0                     (hp_len_qw_0),
    .hp_len_qw_1                     (hp_len_qw_1),
    .hp_ready_0                      (hp_ready_0),
    .hp_ready_1                      (hp_ready_1),
    .hp_release_0                    (hp_release_0),
    .hp_release_1                    (hp_release_1),
    .rx_free_qw                      (rx_free_qw),
    .chunk_cpl                       (chunk_cpl),
    .cpl_qw                          (cpl_qw),
    .huge_page_addr                  (huge_page_addr),
    .qwords_to_rd                    (qwords_to_rd),
    .read_chunk                      (read_chunk),
    .read_chunk_ack                  (read_chunk_ack),
    .send_huge_page_rd_completed     (send_cmp),
    .send_huge_page_rd_completed_ack (send_cmp_ack),
    .busy                            (busy)
  );

  hp_rd_req_sched #(
    .MAX_RD_QW       (8),
    .MAX_OUTSTANDING (16)
  ) dut_b (
    .trn_clk                         (trn_clk),
    .reset                           (reset),
    .hp_addr_0                       (hp_addr_0),
    .hp_addr_1                       (hp_addr_1),
    .hp_len_qw_0                     (hp_len_qw_0),
    .hp_len_qw_1                     (hp_len_qw_1),
    .hp_ready_0                      (b_ready_0),
    .hp_ready_1                      (b_ready_1),
    .hp_release_0                    (b_release_0),
    .hp_release_1                    (b_release_1),
    .rx_free_qw                      (rx_free_qw),
    .chunk_cpl                       (b_cpl),
    .cpl_qw                          (cpl_qw),
    .huge_page_addr                  (b_addr),
    .qwords_to_rd                    (b_qw),
    .read_chunk                      (b_read),
    .read_chunk_ack                  (b_ack),
    .send_huge_page_rd_completed     (b_cmp),
    .send_huge_page_rd_completed_ack (1'b0),
    .busy                            (b_busy)
  );

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge trn_clk);
  endtask

  // sel: 0 = read_chunk, 1 = send_huge_page_rd_completed, 2 = read_chunk of dut_b
  task automatic wait_for(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      case (sel)
        0:       ok = read_chunk;
        1:       ok = send_cmp;
        default: ok = b_read;
      endcase
      if (ok) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({read_chunk, send_cmp, busy, hp_release_0, hp_release_1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {read_chunk, send_cmp, busy, hp_release_0, hp_release_1});
    end
    n_checks++;
    if (huge_page_addr !== 64'd0 || qwords_to_rd !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h qw=%0d want 0/0", huge_page_addr, qwords_to_rd);
    end
    n_checks++;
    if ({b_read, b_busy} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b want 00", {b_read, b_busy});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    hp_addr_0 = 64'h1_0000_0000;
    hp_len_qw_0 = 19'd128;
    rx_free_qw = 10'd512;
    hp_ready_0 = 1'b1;
    tick();
    hp_ready_0 = 1'b0;
    n_checks++;
    if (read_chunk !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lat_n1: got read_chunk=%b want 0", read_chunk);
    end
    tick();
    n_checks++;
    if ({read_chunk, huge_page_addr, qwords_to_rd} !== {1'b1, 64'h1_0000_0000, 9'd64}) begin
      n_fail++;
      $display("FAIL basic_rd0: got %b %h %0d want 1 100000000 64",
               read_chunk, huge_page_addr, qwords_to_rd);
    end
    read_chunk_ack = 1'b1;
    tick();
    read_chunk_ack = 1'b0;
    n_checks++;
    if (read_chunk !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack_drop: got read_chunk=%b want 0", read_chunk);
    end
    tick();
    n_checks++;
    if ({read_chunk, huge_page_addr, qwords_to_rd} !== {1'b1, 64'h1_0000_0200, 9'd64}) begin
      n_fail++;
      $display("FAIL basic_rd1: got %b %h %0d want 1 100000200 64",
               read_chunk, huge_page_addr, qwords_to_rd);
    end
    read_chunk_ack = 1'b1;
    tick();
    read_chunk_ack = 1'b0;
    chunk_cpl = 1'b1;
    cpl_qw = 9'd64;
    repeat (2) tick();
    chunk_cpl = 1'b0;
    wait_for(1, 10, ok);
    n_checks++;
    if (!ok || read_chunk !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_completed: got cmp=%b read_chunk=%b want 1/0", ok, read_chunk);
    end
    send_cmp_ack = 1'b1;
    tick();
    send_cmp_ack = 1'b0;
    n_checks++;
    if ({hp_release_0, hp_release_1, send_cmp} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_release: got %b want 100", {hp_release_0, hp_release_1, send_cmp});
    end
    tick();
    n_checks++;
    if ({hp_release_0, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_idle: got rel0/busy=%b want 00", {hp_release_0, busy});
    end
  endtask

  task automatic test_4k_boundary();
    bit ok;
    logic [63:0] exp_addr [3];
    logic [8:0]  exp_qw [3];
    exp_addr[0] = 64'h2_0000_0F80;
    exp_addr[1] = 64'h2_0000_1000;
    exp_addr[2] = 64'h2_0000_1200;
    exp_qw[0] = 9'd16;
    exp_qw[1] = 9'd64;
    exp_qw[2] = 9'd20;
    hp_addr_1 = 64'h2_0000_0F80;
    hp_len_qw_1 = 19'd100;
    hp_ready_1 = 1'b1;
    tick();
    hp_ready_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_for(0, 20, ok);
      n_checks++;
      if (!ok || huge_page_addr !== exp_addr[i] || qwords_to_rd !== exp_qw[i]) begin
        n_fail++;
        $display("FAIL 4k_chunk%0d: got ok=%b %h %0d want %h %0d", i, ok,
                 huge_page_addr, qwords_to_rd, exp_addr[i], exp_qw[i]);
      end
      read_chunk_ack = 1'b1;
      tick();
      read_chunk_ack = 1'b0;
    end
    chunk_cpl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpl_qw = exp_qw[i];
      tick();
    end
    chunk_cpl = 1'b0;
    wait_for(1, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL 4k_completed: got 0 want 1");
    end
    send_cmp_ack = 1'b1;
    tick();
    send_cmp_ack = 1'b0;
    n_checks++;
    if ({hp_release_0, hp_release_1} !== 2'b01) begin
      n_fail++;
      $display("FAIL 4k_release: got %b want 01", {hp_release_0, hp_release_1});
    end
    tick();
  endtask

  task automatic test_rx_space();
    bit ok;
    hp_addr_0 = 64'h3_0000_0000;
    hp_len_qw_0 = 19'd256;
    rx_free_qw = 10'd100;
    hp_ready_0 = 1'b1;
    tick();
    hp_ready_0 = 1'b0;
    wait_for(0, 10, ok);
    n_checks++;
    if (!ok || huge_page_addr !== 64'h3_0000_0000 || qwords_to_rd !== 9'd64) begin
      n_fail++;
      $display("FAIL rx_first: got ok=%b %h %0d want 300000000 64", ok, huge_page_addr,
               qwords_to_rd);
    end
    read_chunk_ack = 1'b1;
    tick();
    read_chunk_ack = 1'b0;
    // Second chunk must be held; a stray ack while held must be ignored.
    for (int i = 0; i < 8; i++) begin
      read_chunk_ack = (i == 3);
      tick();
      n_checks++;
      if (read_chunk !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_hold%0d: got read_chunk=%b want 0", i, read_chunk);
      end
    end
    read_chunk_ack = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chunk_cpl = 1'b1;
      cpl_qw = 9'd64;
      tick();
      chunk_cpl = 1'b0;
      wait_for(0, 10, ok);
      n_checks++;
      if (!ok || huge_page_addr !== 64'h3_0000_0000 + 64'(k * 512) || qwords_to_rd !== 9'd64)
      begin
        n_fail++;
        $display("FAIL rx_chunk%0d: got ok=%b %h %0d want %h 64", k, ok, huge_page_addr,
                 qwords_to_rd, 64'h3_0000_0000 + 64'(k * 512));
      end
      read_chunk_ack = 1'b1;
      tick();
      read_chunk_ack = 1'b0;
    end
    chunk_cpl = 1'b1;
    tick();
    chunk_cpl = 1'b0;
    wait_for(1, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rx_completed: got 0 want 1");
    end
    send_cmp_ack = 1'b1;
    tick();
    send_cmp_ack = 1'b0;
    n_checks++;
    if ({hp_release_0, hp_release_1} !== 2'b10) begin
      n_fail++;
      $display("FAIL rx_release: got %b want 10", {hp_release_0, hp_release_1});
    end
    tick();
    rx_free_qw = 10'd512;
  endtask

  task automatic test_reset_mid();
    bit ok;
    hp_addr_1 = 64'h5_0000_0000;
    hp_len_qw_1 = 19'd256;
    rx_free_qw = 10'd512;
    hp_ready_1 = 1'b1;
    tick();
    hp_ready_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_for(0, 10, ok);
      read_chunk_ack = 1'b1;
      tick();
      read_chunk_ack = 1'b0;
    end
    wait_for(0, 10, ok);
    n_checks++;
    if (!ok || huge_page_addr !== 64'h5_0000_0600) begin
      n_fail++;
      $display("FAIL rstmid_4th: got ok=%b %h want 500000600", ok, huge_page_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({read_chunk, send_cmp, busy, hp_release_0, hp_release_1} !== 5'b0
        || huge_page_addr !== 64'd0 || qwords_to_rd !== 9'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b %h %0d want 00000 0 0",
               {read_chunk, send_cmp, busy, hp_release_0, hp_release_1},
               huge_page_addr, qwords_to_rd);
    end
    // Index 1 was active before reset; after reset only index 0 may start a page.
    hp_ready_1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({busy, hp_release_0, hp_release_1} !== 3'b0) begin
        n_fail++;
        $display("FAIL rstmid_idle%0d: got busy/rel=%b want 000", i,
                 {busy, hp_release_0, hp_release_1});
      end
    end
    hp_ready_1 = 1'b0;
    tick();
  endtask

  task automatic test_ack_cpl_same();
    bit ok;
    hp_addr_0 = 64'h4_0000_0000;
    hp_len_qw_0 = 19'd128;
    hp_ready_0 = 1'b1;
    tick();
    hp_ready_0 = 1'b0;
    wait_for(0, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL same_start: got read_chunk=0 want 1 (restart at idx0)");
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({read_chunk, huge_page_addr, qwords_to_rd} !== {1'b1, 64'h4_0000_0000, 9'd64}) begin
        n_fail++;
        $display("FAIL same_stable%0d: got %b %h %0d want 1 400000000 64", i,
                 read_chunk, huge_page_addr, qwords_to_rd);
      end
    end
    read_chunk_ack = 1'b1;
    tick();
    read_chunk_ack = 1'b0;
    wait_for(0, 10, ok);
    n_checks++;
    if (!ok || huge_page_addr !== 64'h4_0000_0200) begin
      n_fail++;
      $display("FAIL same_rd1: got ok=%b %h want 400000200", ok, huge_page_addr);
    end
    read_chunk_ack = 1'b1;
    chunk_cpl = 1'b1;
    cpl_qw = 9'd64;
    tick();
    read_chunk_ack = 1'b0;
    chunk_cpl = 1'b0;
    // One request must still be in flight.
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (send_cmp !== 1'b0) begin
        n_fail++;
        $display("FAIL same_early%0d: got completed=%b want 0", i, send_cmp);
      end
    end
    chunk_cpl = 1'b1;
    tick();
    chunk_cpl = 1'b0;
    wait_for(1, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL same_completed: got 0 want 1");
    end
    send_cmp_ack = 1'b1;
    tick();
    send_cmp_ack = 1'b0;
    n_checks++;
    if ({hp_release_0, hp_release_1} !== 2'b10) begin
      n_fail++;
      $display("FAIL same_release: got %b want 10", {hp_release_0, hp_release_1});
    end
    tick();
  endtask

  task automatic test_tag_limit();
    bit ok;
    hp_addr_0 = 64'h6_0000_0000;
    hp_len_qw_0 = 19'd200;
    rx_free_qw = 10'd1023;
    b_ready_0 = 1'b1;
    tick();
    b_ready_0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_for(2, 10, ok);
      n_checks++;
      if (!ok || b_addr !== 64'h6_0000_0000 + 64'(i * 64) || b_qw !== 9'd8) begin
        n_fail++;
        $display("FAIL tag_req%0d: got ok=%b %h %0d want %h 8", i, ok, b_addr, b_qw,
                 64'h6_0000_0000 + 64'(i * 64));
      end
      b_ack = 1'b1;
      tick();
      b_ack = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (b_read !== 1'b0) begin
        n_fail++;
        $display("FAIL tag_hold%0d: got read_chunk=%b want 0", i, b_read);
      end
    end
    b_cpl = 1'b1;
    cpl_qw = 9'd8;
    tick();
    b_cpl = 1'b0;
    wait_for(2, 10, ok);
    n_checks++;
    if (!ok || b_addr !== 64'h6_0000_0400 || b_qw !== 9'd8) begin
      n_fail++;
      $display("FAIL tag_17th: got ok=%b %h %0d want 600000400 8", ok, b_addr, b_qw);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_4k_boundary();
    test_rx_space();
    test_reset_mid();
    test_ack_cpl_same();
    test_tag_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
